// File: rtl/barcode_entry_buffer_pkg.sv
// Shared definitions for the barcode entry buffer.
//   bcb_state_e : entry FSM state (EMPTY / ENTRY / FULL)
//   BLANK_DIGIT : code held in unused digit positions (blank on a 7-seg decoder)
//   MAX_BCD     : largest legal BCD digit value
package barcode_entry_buffer_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ENTRY = 2'd1,
      ST_FULL  = 2'd2
   } bcb_state_e;

   localparam logic [3:0] BLANK_DIGIT = 4'hF;
   localparam logic [3:0] MAX_BCD     = 4'd9;

endpackage

// File: rtl/barcode_digit_shifter.sv
// Bidirectional DIGITS-deep register of 4-bit digits.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset, blanks every position
//   blank_i   : blank all positions (highest priority)
//   pop_i     : shift down, digit k+1 -> k, blank enters the top position
//   push_i    : load digit_i into position 0, digit k -> k+1
//   digit_i   : digit loaded by push_i
//   digits_o  : digit k at bits [4k+3:4k]
module barcode_digit_shifter
   import barcode_entry_buffer_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                blank_i,
   input  logic                pop_i,
   input  logic                push_i,
   input  logic [3:0]          digit_i,
   output logic [4*DIGITS-1:0] digits_o
);

   logic [4*DIGITS-1:0] digits_q, digits_d;

   always_comb begin
      digits_d = digits_q;
      if (blank_i) begin
         digits_d = {DIGITS{BLANK_DIGIT}};
      end else if (pop_i) begin
         digits_d = {BLANK_DIGIT, digits_q[4*DIGITS-1:4]};
      end else if (push_i) begin
         digits_d = {digits_q[4*DIGITS-5:0], digit_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         digits_q <= {DIGITS{BLANK_DIGIT}};
      end else begin
         digits_q <= digits_d;
      end
   end

   assign digits_o = digits_q;

endmodule

// File: rtl/barcode_entry_buffer.sv
// Keypad barcode entry buffer: collects BCD digits newest-first, supports
// backspace/clear, flags a complete barcode until acknowledged, and drops
// a stale partial entry after an idle timeout.
// Ports:
//   CLK, RESET      : clock and synchronous active-high reset
//   DIGIT_VALID/IN  : one-cycle digit offer
//   BACKSPACE       : remove newest digit
//   CLEAR           : discard whole entry
//   BARCODE_ACK     : consumer took the complete barcode
//   BARCODE         : digit k at [4k+3:4k], digit 0 newest, blanks = 4'hF
//   DIGIT_COUNT     : digits held
//   BARCODE_VALID   : complete barcode awaiting ACK
//   DIGIT_REJECT    : pulse, offered digit discarded
//   TIMEOUT         : pulse, partial entry discarded by idle timer
//   DEBUG_STATE     : current FSM state
// Same-cycle priority: RESET > CLEAR > BARCODE_ACK > BACKSPACE > DIGIT_VALID.
// A strobe that loses to a higher-priority one is dropped silently.
module barcode_entry_buffer
   import barcode_entry_buffer_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int TIMEOUT_CYCLES = 250_000_000
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                DIGIT_VALID,
   input  logic [3:0]          DIGIT_IN,
   input  logic                BACKSPACE,
   input  logic                CLEAR,
   input  logic                BARCODE_ACK,
   output logic [4*DIGITS-1:0] BARCODE,
   output logic [3:0]          DIGIT_COUNT,
   output logic                BARCODE_VALID,
   output logic                DIGIT_REJECT,
   output logic                TIMEOUT,
   output bcb_state_e          DEBUG_STATE
);

   // A zero timeout still needs a one-bit counter to keep widths legal.
   localparam int              IDLE_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [3:0]      COUNT_FULL = 4'(DIGITS);

   bcb_state_e        state_q, state_d;
   logic [3:0]        count_q, count_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              reject_q, reject_d;
   logic              timeout_q, timeout_d;
   logic              sh_blank, sh_push, sh_pop;
   logic              acked, digit_ok;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      idle_d    = idle_q;
      reject_d  = 1'b0;
      timeout_d = 1'b0;
      sh_blank  = 1'b0;
      sh_push   = 1'b0;
      sh_pop    = 1'b0;
      acked     = BARCODE_ACK && (state_q == ST_FULL);
      digit_ok  = DIGIT_VALID && (DIGIT_IN <= MAX_BCD) && (state_q != ST_FULL);

      if (CLEAR || acked) begin
         sh_blank = 1'b1;
         state_d  = ST_EMPTY;
         count_d  = 4'd0;
         idle_d   = '0;
      end else if (BACKSPACE) begin
         // In EMPTY backspace does nothing, but it still outranks a digit.
         if (state_q != ST_EMPTY) begin
            sh_pop  = 1'b1;
            count_d = count_q - 4'd1;
            state_d = (count_q == 4'd1) ? ST_EMPTY : ST_ENTRY;
            idle_d  = '0;
         end
      end else begin
         reject_d = DIGIT_VALID && !digit_ok;
         if (digit_ok) begin
            sh_push = 1'b1;
            count_d = count_q + 4'd1;
            state_d = (count_q == COUNT_FULL - 4'd1) ? ST_FULL : ST_ENTRY;
            idle_d  = '0;
         end else if ((state_q == ST_ENTRY) && (TIMEOUT_CYCLES != 0)) begin
            // Fires on the edge where the counter would reach TIMEOUT_CYCLES.
            if (idle_q == IDLE_LAST) begin
               sh_blank  = 1'b1;
               state_d   = ST_EMPTY;
               count_d   = 4'd0;
               idle_d    = '0;
               timeout_d = 1'b1;
            end else if (idle_q != IDLE_MAX) begin
               idle_d = idle_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_EMPTY;
         count_q   <= 4'd0;
         idle_q    <= '0;
         reject_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idle_q    <= idle_d;
         reject_q  <= reject_d;
         timeout_q <= timeout_d;
      end
   end

   barcode_digit_shifter #(
      .DIGITS (DIGITS)
   ) u_shifter (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .blank_i  (sh_blank),
      .pop_i    (sh_pop),
      .push_i   (sh_push),
      .digit_i  (DIGIT_IN),
      .digits_o (BARCODE)
   );

   assign DIGIT_COUNT   = count_q;
   assign BARCODE_VALID = (state_q == ST_FULL);
   assign DIGIT_REJECT  = reject_q;
   assign TIMEOUT       = timeout_q;
   assign DEBUG_STATE   = state_q;

endmodule

// File: tb/tb_barcode_entry_buffer.sv
module tb_barcode_entry_buffer;
   import barcode_entry_buffer_pkg::*;

   localparam int D  = 4;
   localparam int T  = 10;
   localparam int D8 = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, dv, bs, clr, ack;
   logic [3:0]  din;
   logic [15:0] bc;
   logic [3:0]  cnt;
   logic        bvalid, rej, tmo;
   bcb_state_e  st;

   logic        dv8, bs8, clr8, ack8;
   logic [3:0]  din8;
   logic [31:0] bc8;
   logic [3:0]  cnt8;
   logic        bvalid8, rej8, tmo8;
   bcb_state_e  st8;

   barcode_entry_buffer #(.DIGITS(D), .TIMEOUT_CYCLES(T)) dut (
      .CLK(clk), .RESET(rst), .DIGIT_VALID(dv), .DIGIT_IN(din), .BACKSPACE(bs),
      .CLEAR(clr), .BARCODE_ACK(ack), .BARCODE(bc), .DIGIT_COUNT(cnt),
      .BARCODE_VALID(bvalid), .DIGIT_REJECT(rej), .TIMEOUT(tmo), .DEBUG_STATE(st)
   );

   barcode_entry_buffer #(.DIGITS(D8), .TIMEOUT_CYCLES(0)) dut8 (
      .CLK(clk), .RESET(rst), .DIGIT_VALID(dv8), .DIGIT_IN(din8), .BACKSPACE(bs8),
      .CLEAR(clr8), .BARCODE_ACK(ack8), .BARCODE(bc8), .DIGIT_COUNT(cnt8),
      .BARCODE_VALID(bvalid8), .DIGIT_REJECT(rej8), .TIMEOUT(tmo8), .DEBUG_STATE(st8)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // The entry is a list of digits, newest at index 0.
   logic [3:0] m_q[$];
   int         m_idle = 0;
   logic       exp_rej = 1'b0;
   logic       exp_to  = 1'b0;

   task automatic model_step(input logic r, input logic v, input logic [3:0] d,
                             input logic b, input logic c, input logic a);
      exp_rej = 1'b0;
      exp_to  = 1'b0;
      if (r) begin
         m_q.delete();
         m_idle = 0;
      end else if (c || (a && m_q.size() == D)) begin
         m_q.delete();
         m_idle = 0;
      end else if (b) begin
         if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_idle = 0;
         end
      end else begin
         logic took;
         took = 1'b0;
         if (v) begin
            if (d > 4'd9 || m_q.size() == D) exp_rej = 1'b1;
            else begin
               m_q.push_front(d);
               took   = 1'b1;
               m_idle = 0;
            end
         end
         if (!took && m_q.size() > 0 && m_q.size() < D) begin
            m_idle++;
            if (m_idle == T) begin
               m_q.delete();
               m_idle = 0;
               exp_to = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [15:0] exp_barcode();
      logic [15:0] r;
      r = 16'hFFFF;
      for (int k = 0; k < m_q.size(); k++) r[4*k +: 4] = m_q[k];
      return r;
   endfunction

   function automatic bcb_state_e exp_state();
      if (m_q.size() == 0) return ST_EMPTY;
      if (m_q.size() == D) return ST_FULL;
      return ST_ENTRY;
   endfunction

   // ---------------- checks ----------------
   task automatic check_all(input string tag);
      logic [15:0] eb;
      logic [3:0]  ec;
      logic        ev;
      bcb_state_e  es;
      eb = exp_barcode();
      ec = 4'(m_q.size());
      ev = (m_q.size() == D);
      es = exp_state();
      checks++;
      assert (bc === eb) else begin errors++; $error("FAIL %s barcode got %h exp %h", tag, bc, eb); end
      checks++;
      assert (cnt === ec) else begin errors++; $error("FAIL %s count got %0d exp %0d", tag, cnt, ec); end
      checks++;
      assert (bvalid === ev) else begin errors++; $error("FAIL %s valid got %b exp %b", tag, bvalid, ev); end
      checks++;
      assert (rej === exp_rej) else begin errors++; $error("FAIL %s reject got %b exp %b", tag, rej, exp_rej); end
      checks++;
      assert (tmo === exp_to) else begin errors++; $error("FAIL %s timeout got %b exp %b", tag, tmo, exp_to); end
      checks++;
      assert (st === es) else begin errors++; $error("FAIL %s state got %0d exp %0d", tag, st, es); end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin errors++; $error("FAIL %s got %h exp %h", tag, got, exp); end
   endtask

   // ---------------- driver ----------------
   // Inputs change #1 after the edge; outputs are checked #1 after the next edge.
   task automatic apply(input string tag, input logic r, input logic v, input logic [3:0] d,
                        input logic b, input logic c, input logic a);
      rst = r; dv = v; din = d; bs = b; clr = c; ack = a;
      model_step(r, v, d, b, c, a);
      @(posedge clk);
      #1;
      rst = 1'b0; dv = 1'b0; bs = 1'b0; clr = 1'b0; ack = 1'b0;
      check_all(tag);
   endtask

   task automatic digit(input string tag, input logic [3:0] d);
      apply(tag, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input string tag);
      apply(tag, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   logic [31:0] exp8;

   initial begin
      rst = 1'b1; dv = 1'b0; din = 4'd0; bs = 1'b0; clr = 1'b0; ack = 1'b0;
      dv8 = 1'b0; din8 = 4'd0; bs8 = 1'b0; clr8 = 1'b0; ack8 = 1'b0;

      // reset state
      apply("reset", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      apply("reset2", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      check_val("reset_bc8", bc8, 32'hFFFF_FFFF);
      check_val("reset_cnt8", 32'(cnt8), 32'd0);

      // 1,2,3,4 -> 16'h1234, FULL
      digit("e1", 4'd1);
      digit("e2", 4'd2);
      digit("e3", 4'd3);
      check_val("not_valid_at3", 32'(bvalid), 32'd0);
      digit("e4", 4'd4);
      check_val("bc_1234", 32'(bc), 32'h1234);
      check_val("valid_at4", 32'(bvalid), 32'd1);
      // digit in FULL rejected
      digit("full_rej", 4'd7);
      check_val("full_rej_pulse", 32'(rej), 32'd1);
      check_val("full_rej_bc", 32'(bc), 32'h1234);
      idle("full_hold");
      check_val("full_rej_gone", 32'(rej), 32'd0);
      apply("ack", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

      // 5,6, backspace -> FFF5
      digit("e5", 4'd5);
      digit("e6", 4'd6);
      apply("bksp", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check_val("bksp_bc", 32'(bc), 32'hFFF5);
      check_val("bksp_cnt", 32'(cnt), 32'd1);
      apply("clear", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

      // illegal digit in EMPTY, backspace and ack in EMPTY are no-ops
      digit("bad_empty", 4'hA);
      check_val("bad_rej", 32'(rej), 32'd1);
      check_val("bad_cnt", 32'(cnt), 32'd0);
      apply("bs_empty", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      apply("ack_empty", 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1);

      // timeout after 10 idle cycles (the ack_empty step entered one digit)
      apply("clr_pre_to", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      digit("to_d", 4'd3);
      for (int i = 0; i < T; i++) idle("to_idle");
      check_val("to_pulse", 32'(tmo), 32'd1);
      check_val("to_bc", 32'(bc), 32'hFFFF);
      idle("to_after");
      check_val("to_one_cycle", 32'(tmo), 32'd0);

      // 9 idle cycles then a digit: no timeout
      digit("nt_d1", 4'd2);
      for (int i = 0; i < T - 1; i++) idle("nt_idle");
      digit("nt_d2", 4'd8);
      check_val("nt_cnt", 32'(cnt), 32'd2);
      check_val("nt_tmo", 32'(tmo), 32'd0);
      // FULL does not time out
      digit("nt_d3", 4'd0);
      digit("nt_d4", 4'd9);
      for (int i = 0; i < T + 3; i++) idle("full_idle");

      // ACK + BACKSPACE + DIGIT in FULL -> EMPTY, no reject
      apply("ack_combo", 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
      check_val("combo_cnt", 32'(cnt), 32'd0);
      check_val("combo_rej", 32'(rej), 32'd0);

      // CLEAR and RESET mid-entry
      digit("m1", 4'd4);
      digit("m2", 4'd6);
      apply("mid_clear", 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
      digit("m3", 4'd7);
      apply("mid_reset", 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1);
      check_val("mid_reset_bc", 32'(bc), 32'hFFFF);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic          r, v, b, c, a;
         logic [3:0]    d;
         r = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 99) < 55);
         d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         b = ($urandom_range(0, 99) < 12);
         c = ($urandom_range(0, 99) < 3);
         a = ($urandom_range(0, 99) < 15);
         // quiet stretches let the idle timer expire now and then
         if ($urandom_range(0, 3) == 0) begin v = 1'b0; b = 1'b0; c = 1'b0; a = 1'b0; end
         apply("rand", r, v, d, b, c, a);
      end

      // 8-digit instance: eight entries -> BARCODE_VALID
      exp8 = 32'hFFFF_FFFF;
      for (int i = 0; i < D8; i++) begin
         din8 = 4'($urandom_range(0, 9));
         dv8  = 1'b1;
         exp8 = {exp8[27:0], din8};
         @(posedge clk);
         #1;
         dv8 = 1'b0;
         if (i == D8 - 2) check_val("d8_not_valid_at7", 32'(bvalid8), 32'd0);
      end
      check_val("d8_valid", 32'(bvalid8), 32'd1);
      check_val("d8_bc", bc8, exp8);
      check_val("d8_cnt", 32'(cnt8), 32'd8);
      check_val("d8_rej", 32'(rej8), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
